pad_remap: RTL

//  Parametrised, run-time programmable button remapper between the PSX console poller and the N64 controller.
//  - Takes one active-low button frame per poll.
//  - Produces a registered, active-high output frame.
//  - Each output bit has a table entry: source bit index and mode (off / direct / turbo / toggle).
//  - Replaces fixed wire-level mapping; the table can be rewritten live through a config write port.

---
 rtl/pad_remap_if.sv | 28 ++
 rtl/pad_remap.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pad_remap_if.sv
// Button frame and table-config bundle between the PSX poller and the pad_remap block.
// master drives frames and config writes; slave (pad_remap) returns the mapped frame.
interface pad_remap_if #(
   parameter int unsigned IN_BITS  = 16,
   parameter int unsigned OUT_BITS = 16
);
   localparam int unsigned SW = $clog2(IN_BITS);
   localparam int unsigned AW = $clog2(OUT_BITS);

   logic [IN_BITS-1:0]  in_btns;
   logic                in_valid;
   logic                cfg_we;
   logic [AW-1:0]       cfg_addr;
   logic [1:0]          cfg_mode;
   logic [SW-1:0]       cfg_src;
   logic [OUT_BITS-1:0] out_btns;
   logic                out_valid;

   modport master (
      output in_btns, in_valid, cfg_we, cfg_addr, cfg_mode, cfg_src,
      input  out_btns, out_valid
   );

   modport slave (
      input  in_btns, in_valid, cfg_we, cfg_addr, cfg_mode, cfg_src,
      output out_btns, out_valid
   );
endinterface

// File: rtl/pad_remap.sv
// Run-time programmable button remapper: active-low source frame in, registered active-high frame out.
// Optional turbo counter/phase is built only when PAD_REMAP_TURBO_EN is defined.
module pad_remap #(
   parameter int unsigned IN_BITS      = 16,
   parameter int unsigned OUT_BITS     = 16,
   parameter int unsigned TURBO_FRAMES = 4
) (
   input logic       sample_clk,
   input logic       reset,
   pad_remap_if.slave bus
);
   localparam int unsigned SW = $clog2(IN_BITS);

   typedef enum logic [1:0] {
      ModeOff    = 2'b00,
      ModeDirect = 2'b01,
      ModeTurbo  = 2'b10,
      ModeToggle = 2'b11
   } mode_e;

   // Default source for each output bit; 32 marks an unmapped entry.
   function automatic int unsigned default_idx(input int unsigned idx);
      case (idx)
         0:       return 14;
         1:       return 13;
         4:       return 4;
         5:       return 6;
         6:       return 7;
         7:       return 5;
         default: return 32;
      endcase
   endfunction

   // A default whose source cannot exist on this frame width always reads 0, so store it as off.
   function automatic logic default_on(input int unsigned idx);
      return default_idx(idx) < IN_BITS;
   endfunction

   mode_e               mode_q [OUT_BITS];
   logic [SW-1:0]       src_q  [OUT_BITS];
   logic [OUT_BITS-1:0] tog_q;
   logic [OUT_BITS-1:0] prev_q;
   logic [OUT_BITS-1:0] out_q;
   logic                valid_q;

   logic [OUT_BITS-1:0] press;
   logic [OUT_BITS-1:0] tog_d;
   logic [OUT_BITS-1:0] out_d;
   logic                turbo_gate;

`ifdef PAD_REMAP_TURBO_EN
   localparam int unsigned CW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
   localparam logic [CW-1:0] CntLast = CW'(TURBO_FRAMES - 1);

   logic [CW-1:0] turbo_cnt_q;
   logic          turbo_phase_q;

   always_ff @(posedge sample_clk) begin
      if (reset) begin
         turbo_cnt_q   <= '0;
         turbo_phase_q <= 1'b1;
      end else if (bus.in_valid) begin
         if (turbo_cnt_q == CntLast) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= ~turbo_phase_q;
         end else begin
            turbo_cnt_q <= turbo_cnt_q + 1'b1;
         end
      end
   end

   assign turbo_gate = turbo_phase_q;
`else
   assign turbo_gate = 1'b1;
`endif

   always_comb begin
      press = '0;
      tog_d = tog_q;
      out_d = '0;
      for (int i = 0; i < OUT_BITS; i++) begin
         if (int'(src_q[i]) < int'(IN_BITS)) begin
            press[i] = ~bus.in_btns[src_q[i]];
         end
         case (mode_q[i])
            ModeDirect: out_d[i] = press[i];
            ModeTurbo:  out_d[i] = press[i] & turbo_gate;
            ModeToggle: begin
               tog_d[i] = tog_q[i] ^ (press[i] & ~prev_q[i]);
               out_d[i] = tog_d[i];
            end
            default:    out_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sample_clk) begin
      if (reset) begin
         for (int i = 0; i < OUT_BITS; i++) begin
            mode_q[i] <= default_on(i) ? ModeDirect : ModeOff;
            src_q[i]  <= default_on(i) ? SW'(default_idx(i)) : '0;
         end
         tog_q   <= '0;
         prev_q  <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            out_q  <= out_d;
            tog_q  <= tog_d;
            prev_q <= press;
         end
         // Config write lands after the frame update so a same-cycle frame sees the old entry.
         for (int i = 0; i < OUT_BITS; i++) begin
            if (bus.cfg_we && (int'(bus.cfg_addr) == i)) begin
               mode_q[i] <= mode_e'(bus.cfg_mode);
               src_q[i]  <= bus.cfg_src;
               tog_q[i]  <= 1'b0;
               prev_q[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.out_btns  = out_q;
   assign bus.out_valid = valid_q;
endmodule
